// File: rtl/eci_cmd_defs.sv
// Shared ECI command field widths used by the VC merge/split blocks.
package eci_cmd_defs;
  localparam int ECI_ADDR_BITS = 40;
  localparam int ECI_ID_BITS   = 6;
  localparam int ECI_DATA_BITS = 64;
endpackage

// File: rtl/eci_vc_merge_rd_2vc.sv
// Merges two VC read-address streams round-robin into one AR channel (1-cycle registered, no bubbles);
// R beats are routed back by the VC bit of rid with zero latency; a VC stalls only when its outstanding count is full.
module eci_vc_merge_rd_2vc
  import eci_cmd_defs::*;
#(
  parameter int N_OUTSTANDING = 16
) (
  input  logic                          aclk,
  input  logic                          areset,

  input  logic [1:0][ECI_ADDR_BITS-1:0] s_araddr,
  input  logic [1:0][ECI_ID_BITS-1:0]   s_arid,
  input  logic [1:0][7:0]               s_arlen,
  input  logic [1:0]                    s_arvalid,
  output logic [1:0]                    s_arready,

  output logic [1:0][ECI_DATA_BITS-1:0] s_rdata,
  output logic [1:0][ECI_ID_BITS-1:0]   s_rid,
  output logic [1:0]                    s_rlast,
  output logic [1:0]                    s_rvalid,
  input  logic [1:0]                    s_rready,

  output logic [ECI_ADDR_BITS-1:0]      m_araddr,
  output logic [ECI_ID_BITS:0]          m_arid,
  output logic [7:0]                    m_arlen,
  output logic                          m_arvalid,
  input  logic                          m_arready,

  input  logic [ECI_DATA_BITS-1:0]      m_rdata,
  input  logic [ECI_ID_BITS:0]          m_rid,
  input  logic                          m_rlast,
  input  logic                          m_rvalid,
  output logic                          m_rready
);

  typedef struct packed {
    logic [ECI_ADDR_BITS-1:0] addr;
    logic [ECI_ID_BITS:0]     id;
    logic [7:0]               len;
  } ar_t;

  localparam logic [7:0] MAX_OUT = 8'(N_OUTSTANDING);

  ar_t            ar_q;
  logic           ar_vld;
  logic [1:0][7:0] cnt;
  logic           lg;
  logic           err_q;

  logic [1:0] req;
  logic [1:0] grant;
  logic [1:0] ar_hs;
  logic [1:0] dec;
  logic       accept;
  logic       gnt_vc;
  logic       r_vc;
  logic       r_last_hs;

  always_comb begin
    req = 2'b00;
    for (int v = 0; v < 2; v++) begin
      req[v] = s_arvalid[v] && (cnt[v] < MAX_OUT);
    end
  end

  // lg holds the VC that won last; on contention the other one goes next.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = lg ? 2'b01 : 2'b10;
    end
  end

  assign accept    = !ar_vld || m_arready;
  assign s_arready = (areset || !accept) ? 2'b00 : grant;
  assign ar_hs     = s_arvalid & s_arready;
  assign gnt_vc    = ar_hs[1];

  assign m_araddr  = ar_q.addr;
  assign m_arid    = ar_q.id;
  assign m_arlen   = ar_q.len;
  assign m_arvalid = ar_vld;

  assign r_vc      = m_rid[ECI_ID_BITS];
  assign s_rvalid  = m_rvalid ? (r_vc ? 2'b10 : 2'b01) : 2'b00;
  assign s_rdata   = {2{m_rdata}};
  assign s_rid     = {2{m_rid[ECI_ID_BITS-1:0]}};
  assign s_rlast   = {2{m_rlast}};
  assign m_rready  = s_rready[r_vc];
  assign r_last_hs = m_rvalid && m_rready && m_rlast;
  assign dec       = r_last_hs ? (r_vc ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge aclk) begin
    if (areset) begin
      ar_vld <= 1'b0;
      ar_q   <= '0;
      cnt    <= '0;
      lg     <= 1'b1;
      err_q  <= 1'b0;
    end else begin
      if (|ar_hs) begin
        ar_vld  <= 1'b1;
        ar_q    <= '{addr: s_araddr[gnt_vc],
                     id:   {gnt_vc, s_arid[gnt_vc]},
                     len:  s_arlen[gnt_vc]};
        lg      <= gnt_vc;
      end else if (m_arready) begin
        ar_vld <= 1'b0;
      end

      // A last beat with nothing outstanding is a protocol error; the count must not wrap.
      for (int v = 0; v < 2; v++) begin
        if (ar_hs[v] && !dec[v]) begin
          cnt[v] <= cnt[v] + 8'd1;
        end else if (dec[v] && !ar_hs[v]) begin
          if (cnt[v] == 8'd0) begin
            err_q <= 1'b1;
          end else begin
            cnt[v] <= cnt[v] - 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: doc/eci_vc_merge_rd_2vc.md
ECI_VC_MERGE_RD_2VC -- requirements
Module: eci_vc_merge_rd_2vc

Interface
REQ-001 SHALL have parameter N_OUTSTANDING, default 16: maximum in-flight read bursts per VC (1..255).
REQ-002 SHALL take ECI_ADDR_BITS, ECI_ID_BITS and ECI_DATA_BITS from eci_cmd_defs.
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports named as follows:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
REQ-004 SHALL have the VC-side read address ports, indexed by VC number v:
- s_araddr  in  [1:0][ECI_ADDR_BITS]  per-VC read address
- s_arid  in  [1:0][ECI_ID_BITS]  per-VC read ID
- s_arlen  in  [1:0][8]  per-VC burst length minus 1
- s_arvalid  in  [1:0]  per-VC address valid
- s_arready  out  [1:0]  per-VC address ready
REQ-005 SHALL have the VC-side read data ports:
- s_rdata  out  [1:0][ECI_DATA_BITS]  per-VC read data
- s_rid  out  [1:0][ECI_ID_BITS]  per-VC response ID
- s_rlast  out  [1:0]  per-VC last beat
- s_rvalid  out  [1:0]  per-VC data valid
- s_rready  in  [1:0]  per-VC data ready
REQ-006 SHALL have the memory-side read address ports:
- m_araddr  out  ECI_ADDR_BITS  merged address
- m_arid  out  ECI_ID_BITS+1  merged ID, {vc, id}
- m_arlen  out  8  burst length minus 1
- m_arvalid  out  1  address valid
- m_arready  in  1  address ready
REQ-007 SHALL have the memory-side read data ports:
- m_rdata  in  ECI_DATA_BITS  read data
- m_rid  in  ECI_ID_BITS+1  response ID
- m_rlast  in  1  last beat
- m_rvalid  in  1  data valid
- m_rready  out  1  data ready

Function
REQ-008 SHALL keep one outstanding counter per VC, cnt[v], 8 bits wide; VC v is eligible only when cnt[v] < N_OUTSTANDING.
REQ-009 SHALL arbitrate round-robin between requesting eligible VCs, driven by a last-grant register lg:
- both VCs request: grant goes to the VC that is not lg
- one VC requests: grant goes to that VC
- lg updates only on an accepted s_ar handshake.
REQ-010 SHALL hold m_ar* in a one-entry output register, with accept = !m_arvalid || m_arready.
REQ-011 SHALL assert s_arready[v] only when grant[v] && accept; at most one s_arready bit is high per cycle.
REQ-012 SHALL load the register on the cycle after an s_ar handshake, giving 1-cycle latency: m_arid = {v, s_arid[v]}, with araddr and arlen unchanged.
REQ-013 SHALL keep the register full and its contents stable while m_arvalid && !m_arready (AXI stability rule).
REQ-014 SHALL, when m_arready and a new s_ar handshake occur in the same cycle, load the new request so m_arvalid stays 1 with no bubble.
REQ-015 SHALL route the R channel combinationally with zero latency, using v = m_rid[ECI_ID_BITS]:
- s_rvalid[v] = m_rvalid; the other VC's s_rvalid = 0
- s_rdata, s_rid = m_rid[ECI_ID_BITS-1:0], and s_rlast are broadcast to both VCs
- m_rready = s_rready[v].
REQ-016 SHALL increment cnt[v] on an s_ar handshake for VC v.
REQ-017 SHALL decrement cnt[v] on an R handshake with m_rlast=1 routed to VC v.
REQ-018 SHALL leave cnt[v] unchanged when an increment and a decrement for the same VC occur in the same cycle.
REQ-019 SHALL never let cnt[v] wrap: a decrement at 0 is ignored and flags protocol error err_q.
REQ-020 SHALL hold err_q sticky; it is internal only and visible to simulation.
REQ-021 SHALL block only the full VC when cnt[v] = N_OUTSTANDING, while the other VC continues to be granted.

Reset
REQ-022 SHALL, while areset=1 at a rising aclk edge, force:
- m_arvalid = 0 and all m_ar* register contents = 0
- cnt[0] = cnt[1] = 0
- lg = 1, so VC0 wins the first contention
- err_q = 0.
REQ-023 SHALL drive s_arready = 0 throughout reset.
REQ-024 SHALL drop a request held in the output register when reset is asserted mid-operation.
REQ-025 SHALL treat R beats arriving after reset for pre-reset requests as hitting the REQ-019 error path; the block does no recovery.

Verification
REQ-026 SHALL cover: single VC1 request (addr 0x1000, id 3, len 0) -> m_arvalid next cycle, m_arid = {1,3}; R with rid {1,3}, rlast=1 -> s_rvalid[1]=1, s_rid[1]=3, cnt[1] back to 0.
REQ-027 SHALL cover: both VCs continuously valid with m_arready=1 -> grants strictly alternate VC0, VC1, VC0, ..., one request issued per cycle, no bubbles.
REQ-028 SHALL cover: N_OUTSTANDING=4, VC0 issues 4 requests with no responses -> s_arready[0]=0 and VC1 still issued; one rlast for VC0 -> VC0 accepted again the next cycle.
REQ-029 SHALL cover: m_arready held 0 for 5 cycles -> m_ar* stable, s_arready=0 for both VCs; when m_arready=1, the queued VC request is loaded in the same cycle.
REQ-030 SHALL cover: an R burst to VC1 with s_rready[1] toggling 1,0,1 -> m_rready mirrors it, the beat is held while stalled, s_rvalid[0] stays 0.
REQ-031 SHALL cover: areset=1 with the register full and cnt[1]=2 -> next cycle m_arvalid=0, cnt=0, first contention granted to VC0.
